// File: rtl/terrain_query_arbiter.sv
// terrain_query_arbiter
// ---------------------
// Shares the terrain bitmap's single neighbourhood-lookup port between
// several moving objects (aliens, gold bags). Requests are served one at a
// time in round-robin order, and new queries are only issued while
// query_window is high so lookups never collide with pixel rendering.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   query_window    1 = a new query may be issued
//   req             level request per requester, held until its done pulse
//   req_x, req_y    packed top-left coordinates, requester i at [i*COORD_W +: COORD_W]
//   done            one-cycle pulse per requester when its result is updated
//   result          packed {up,down,left,right} free flags, requester i at [i*4 +: 4]
//   bm_qvalid       one-cycle query strobe to the terrain bitmap
//   bm_qx, bm_qy    query coordinates, held from ISSUE until STORE
//   bm_rvalid       bitmap response valid
//   bm_rdata        bitmap response free flags
//   busy            1 while a query is in flight (state != IDLE)
//   timeout_err     sticky flag, set whenever a query is abandoned
module terrain_query_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int COORD_W = 11,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       query_window,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ*4-1:0]       result,
    output logic                       bm_qvalid,
    output logic [COORD_W-1:0]         bm_qx,
    output logic [COORD_W-1:0]         bm_qy,
    input  logic                       bm_rvalid,
    input  logic [3:0]                 bm_rdata,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int              ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
    // The counter value seen during the final permitted WAIT cycle.
    localparam logic [3:0]      WAIT_LAST = 4'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        STORE
    } stateT;

    stateT              state;
    logic [ID_W-1:0]    lastGrant;
    logic [ID_W-1:0]    grantId;
    logic [3:0]         waitCount;

    logic               winnerFound;
    logic [ID_W-1:0]    winnerId;
    logic [COORD_W-1:0] winnerX;
    logic [COORD_W-1:0] winnerY;

    // Round-robin winner search. The first pass looks at requesters above
    // the last grant, the second pass wraps around to the ones at or below
    // it, which together is a scan starting at lastGrant+1 modulo NUM_REQ.
    // The winner's coordinates are picked here too so the IDLE state can
    // latch them straight into the query registers.
    always_comb begin
        winnerFound = 1'b0;
        winnerId    = '0;
        winnerX     = '0;
        winnerY     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!winnerFound && req[i] && (ID_W'(i) > lastGrant)) begin
                winnerFound = 1'b1;
                winnerId    = ID_W'(i);
                winnerX     = req_x[i*COORD_W +: COORD_W];
                winnerY     = req_y[i*COORD_W +: COORD_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!winnerFound && req[i] && (ID_W'(i) <= lastGrant)) begin
                winnerFound = 1'b1;
                winnerId    = ID_W'(i);
                winnerX     = req_x[i*COORD_W +: COORD_W];
                winnerY     = req_y[i*COORD_W +: COORD_W];
            end
        end
    end

    // Query sequencer. Every output is a register, so each value is
    // computed on the edge that enters the state where it must be visible:
    // bm_qvalid is set on the IDLE->ISSUE edge, and result/done are written
    // on the WAIT->STORE edge so they appear during the STORE cycle.
    // The bitmap response carries no id; with only one query outstanding
    // it always belongs to grantId. bm_rvalid is ignored outside WAIT, and
    // a response in the last permitted WAIT cycle still wins over the
    // timeout. A timed-out query stores all-blocked, the safe answer for
    // movement logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lastGrant   <= LAST_ID;
            grantId     <= '0;
            waitCount   <= '0;
            bm_qvalid   <= 1'b0;
            bm_qx       <= '0;
            bm_qy       <= '0;
            done        <= '0;
            result      <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            bm_qvalid <= 1'b0;
            done      <= '0;
            case (state)
                IDLE: begin
                    if (query_window && winnerFound) begin
                        grantId   <= winnerId;
                        bm_qx     <= winnerX;
                        bm_qy     <= winnerY;
                        bm_qvalid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    waitCount <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (bm_rvalid) begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (grantId == ID_W'(i)) begin
                                result[i*4 +: 4] <= bm_rdata;
                                done[i]          <= 1'b1;
                            end
                        end
                        state <= STORE;
                    end else if (waitCount == WAIT_LAST) begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (grantId == ID_W'(i)) begin
                                result[i*4 +: 4] <= 4'b0000;
                                done[i]          <= 1'b1;
                            end
                        end
                        timeout_err <= 1'b1;
                        state       <= STORE;
                    end else begin
                        waitCount <= waitCount + 4'd1;
                    end
                end
                STORE: begin
                    lastGrant <= grantId;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_terrain_query_arbiter.sv
// tb_terrain_query_arbiter
// ------------------------
// Directed bench for terrain_query_arbiter. A transaction-level model tracks
// the age of the query in flight and the stored results; a compare process
// checks every DUT output against it on each falling edge, and the
// directed sequence adds hand-computed literal checks. A small bitmap
// responder answers each bm_qvalid after a programmable latency.
module tb_terrain_query_arbiter;

    localparam int NUM_REQ = 4;
    localparam int COORD_W = 11;
    localparam int TIMEOUT = 15;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       query_window;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*COORD_W-1:0] req_x;
    logic [NUM_REQ*COORD_W-1:0] req_y;
    logic [NUM_REQ-1:0]         done;
    logic [NUM_REQ*4-1:0]       result;
    logic                       bm_qvalid;
    logic [COORD_W-1:0]         bm_qx;
    logic [COORD_W-1:0]         bm_qy;
    logic                       bm_rvalid;
    logic [3:0]                 bm_rdata;
    logic                       busy;
    logic                       timeout_err;

    int total = 0;
    int bad   = 0;
    logic checking = 1'b0;

    // Bitmap responder controls: respLat=0 means never answer.
    int         respLat    = 0;
    logic       respFromQx = 1'b0;
    logic [3:0] respFixed  = 4'h0;
    int         respCnt    = 0;
    logic       autoRv     = 1'b0;
    logic [3:0] autoData   = 4'h0;
    logic       manualRv   = 1'b0;
    logic [3:0] manualData = 4'h0;

    assign bm_rvalid = autoRv | manualRv;
    assign bm_rdata  = autoRv ? autoData : manualData;

    terrain_query_arbiter #(
        .NUM_REQ(NUM_REQ),
        .COORD_W(COORD_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .query_window(query_window),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .done        (done),
        .result      (result),
        .bm_qvalid   (bm_qvalid),
        .bm_qx       (bm_qx),
        .bm_qy       (bm_qy),
        .bm_rvalid   (bm_rvalid),
        .bm_rdata    (bm_rdata),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Bitmap responder: a query strobe seen on falling edge c produces a
    // response held across the rising edge that ends cycle c+respLat.
    always @(negedge clk) begin
        autoRv = 1'b0;
        if (respCnt > 0) begin
            respCnt = respCnt - 1;
            if (respCnt == 0) begin
                autoRv   = 1'b1;
                autoData = respFromQx ? bm_qx[3:0] : respFixed;
            end
        end
        if (bm_qvalid && respLat > 0) begin
            respCnt = respLat;
        end
    end

    // Reference model. mAge is 0 when idle, 1 in the strobe cycle, and
    // counts up while waiting; the wait cycle number is mAge-1, and the
    // query is abandoned after TIMEOUT wait cycles without a response.
    // mStoring marks the single cycle in which done is shown.
    int                 mAge     = 0;
    logic               mStoring = 1'b0;
    int                 mId      = 0;
    int                 mLast    = NUM_REQ - 1;
    int                 mCand    = 0;
    logic               mErr     = 1'b0;
    logic [3:0]         mRes [NUM_REQ];
    logic               eQv      = 1'b0;
    logic [NUM_REQ-1:0] eDone    = '0;
    logic [COORD_W-1:0] eQx      = '0;
    logic [COORD_W-1:0] eQy      = '0;
    logic [NUM_REQ*4-1:0] expResPacked;

    // Model update on each rising edge, using the inputs the DUT samples.
    always @(posedge clk) begin
        if (reset) begin
            mAge = 0; mStoring = 1'b0; mId = 0; mLast = NUM_REQ - 1; mErr = 1'b0;
            eQv = 1'b0; eDone = '0; eQx = '0; eQy = '0;
            for (int k = 0; k < NUM_REQ; k++) mRes[k] = 4'h0;
        end else begin
            eQv   = 1'b0;
            eDone = '0;
            if (mAge == 0) begin
                if (query_window && req != 0) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        mCand = (mLast + 1 + k) % NUM_REQ;
                        if (req[mCand]) begin
                            mId = mCand;
                            break;
                        end
                    end
                    eQx  = req_x[mId*COORD_W +: COORD_W];
                    eQy  = req_y[mId*COORD_W +: COORD_W];
                    eQv  = 1'b1;
                    mAge = 1;
                end
            end else if (mStoring) begin
                mStoring = 1'b0;
                mAge     = 0;
                mLast    = mId;
            end else if (mAge == 1) begin
                mAge = 2;
            end else if (bm_rvalid) begin
                mRes[mId]   = bm_rdata;
                eDone[mId]  = 1'b1;
                mStoring    = 1'b1;
            end else if (mAge - 1 == TIMEOUT) begin
                mRes[mId]   = 4'h0;
                mErr        = 1'b1;
                eDone[mId]  = 1'b1;
                mStoring    = 1'b1;
            end else begin
                mAge = mAge + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < NUM_REQ; k++) expResPacked[k*4 +: 4] = mRes[k];
            checkOutput("cmpDone",   64'(done),        64'(eDone));
            checkOutput("cmpResult", 64'(result),      64'(expResPacked));
            checkOutput("cmpQvalid", 64'(bm_qvalid),   64'(eQv));
            checkOutput("cmpQx",     64'(bm_qx),       64'(eQx));
            checkOutput("cmpQy",     64'(bm_qy),       64'(eQy));
            checkOutput("cmpBusy",   64'(busy),        64'(mAge != 0));
            checkOutput("cmpErr",    64'(timeout_err), 64'(mErr));
        end
    end

    task automatic applyStimulus(input logic win, input logic [NUM_REQ-1:0] r);
        query_window = win;
        req          = r;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setCoord(input int i, input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        req_x[i*COORD_W +: COORD_W] = x;
        req_y[i*COORD_W +: COORD_W] = y;
    endtask

    // Waits for a done pulse, bounded; returns the number of falling edges taken.
    task automatic waitDone(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (done == 0 && cycles < limit);
        checkOutput("doneWithinBound", 64'(done != 0), 64'd1);
    endtask

    task automatic resetPulse();
        reset = 1'b1;
        applyStimulus(1'b0, '0);
        tick(2);
        reset = 1'b0;
    endtask

    function automatic logic [3:0] resOf(input int i);
        return result[i*4 +: 4];
    endfunction

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with literal expectations.
    initial begin
        int cyc;
        int id;
        int doneSeen;
        int expOrder [5] = '{0, 1, 2, 3, 0};

        reset = 1'b1;
        query_window = 1'b0;
        req = '0;
        req_x = '0;
        req_y = '0;
        tick(3);
        checking = 1'b1;
        checkOutput("resetResult", 64'(result), 64'd0);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetErr", 64'(timeout_err), 64'd0);
        checkOutput("resetQvalid", 64'(bm_qvalid), 64'd0);
        reset = 1'b0;

        // Single request, bitmap latency 2.
        setCoord(0, 11'd100, 11'd200);
        respLat = 2; respFromQx = 1'b0; respFixed = 4'b1010;
        applyStimulus(1'b1, 4'b0001);
        tick(1);
        checkOutput("singleQvalid", 64'(bm_qvalid), 64'd1);
        checkOutput("singleQx", 64'(bm_qx), 64'd100);
        checkOutput("singleQy", 64'(bm_qy), 64'd200);
        checkOutput("singleBusy1", 64'(busy), 64'd1);
        tick(1);
        checkOutput("singleBusy2", 64'(busy), 64'd1);
        checkOutput("singleNoDone2", 64'(done), 64'd0);
        tick(1);
        checkOutput("singleBusy3", 64'(busy), 64'd1);
        tick(1);
        checkOutput("singleDone", 64'(done), 64'b0001);
        checkOutput("singleResult", 64'(resOf(0)), 64'b1010);
        applyStimulus(1'b1, '0);
        tick(1);
        checkOutput("singleIdleBusy", 64'(busy), 64'd0);
        tick(2);

        // Round robin from reset, id-encoded response data (5+i).
        resetPulse();
        for (int i = 0; i < NUM_REQ; i++) setCoord(i, 11'(i*16 + 5 + i), 11'(300 + i));
        respLat = 1; respFromQx = 1'b1;
        applyStimulus(1'b1, 4'b1111);
        for (int n = 0; n < 5; n++) begin
            waitDone(20, cyc);
            id = -1;
            for (int k = 0; k < NUM_REQ; k++) if (done[k]) id = k;
            checkOutput("rrOrder", 64'(id), 64'(expOrder[n]));
            if (n == 4) applyStimulus(1'b1, '0);
        end
        for (int i = 0; i < NUM_REQ; i++) checkOutput("rrResult", 64'(resOf(i)), 64'(5 + i));
        tick(2);

        // Window gating: nothing issues until the window opens; closing it
        // mid-query still lets the query finish.
        setCoord(2, 11'(2*16 + 12), 11'd77);
        respLat = 3;
        applyStimulus(1'b0, 4'b0100);
        for (int n = 0; n < 4; n++) begin
            tick(1);
            checkOutput("gatedQvalid", 64'(bm_qvalid), 64'd0);
            checkOutput("gatedBusy", 64'(busy), 64'd0);
        end
        applyStimulus(1'b1, 4'b0100);
        tick(1);
        checkOutput("windowQvalid", 64'(bm_qvalid), 64'd1);
        checkOutput("windowQx", 64'(bm_qx), 64'd44);
        tick(1);
        applyStimulus(1'b0, 4'b0100);
        waitDone(10, cyc);
        checkOutput("windowDoneCycle", 64'(cyc), 64'd3);
        checkOutput("windowDone", 64'(done), 64'b0100);
        checkOutput("windowResult", 64'(resOf(2)), 64'd12);
        applyStimulus(1'b0, '0);
        tick(2);

        // Stray response while idle changes nothing.
        manualData = 4'hF; manualRv = 1'b1;
        tick(1);
        manualRv = 1'b0;
        tick(2);
        checkOutput("strayResult", 64'(result), 64'h8C65);
        checkOutput("strayBusy", 64'(busy), 64'd0);

        // Response on the very last wait cycle counts as valid.
        respLat = TIMEOUT; respFromQx = 1'b0; respFixed = 4'b0110;
        applyStimulus(1'b1, 4'b0010);
        waitDone(40, cyc);
        checkOutput("lateDoneCycle", 64'(cyc), 64'd17);
        checkOutput("lateDone", 64'(done), 64'b0010);
        checkOutput("lateResult", 64'(resOf(1)), 64'b0110);
        checkOutput("lateErr", 64'(timeout_err), 64'd0);
        applyStimulus(1'b0, '0);
        tick(2);

        // No response at all: abandoned query stores all-blocked.
        respLat = 0;
        applyStimulus(1'b1, 4'b1000);
        waitDone(40, cyc);
        checkOutput("toDoneCycle", 64'(cyc), 64'd17);
        checkOutput("toDone", 64'(done), 64'b1000);
        checkOutput("toResult", 64'(resOf(3)), 64'd0);
        checkOutput("toErr", 64'(timeout_err), 64'd1);
        applyStimulus(1'b0, '0);
        tick(3);
        checkOutput("toErrSticky", 64'(timeout_err), 64'd1);
        respLat = 2; respFixed = 4'b1111;
        applyStimulus(1'b1, 4'b1000);
        waitDone(10, cyc);
        checkOutput("afterToCycle", 64'(cyc), 64'd4);
        checkOutput("afterToResult", 64'(resOf(3)), 64'b1111);
        checkOutput("afterToErr", 64'(timeout_err), 64'd1);
        applyStimulus(1'b0, '0);
        tick(2);

        // Reset during WAIT; the bitmap answers after reset is released.
        respLat = 6; respFixed = 4'b1001;
        applyStimulus(1'b1, 4'b0001);
        tick(3);
        checkOutput("midBusy", 64'(busy), 64'd1);
        reset = 1'b1;
        applyStimulus(1'b0, '0);
        tick(2);
        reset = 1'b0;
        checkOutput("midResetResult", 64'(result), 64'd0);
        checkOutput("midResetBusy", 64'(busy), 64'd0);
        checkOutput("midResetErr", 64'(timeout_err), 64'd0);
        doneSeen = 0;
        for (int n = 0; n < 6; n++) begin
            tick(1);
            if (done != 0) doneSeen++;
        end
        checkOutput("midNoDone", 64'(doneSeen), 64'd0);
        checkOutput("midResultAfter", 64'(result), 64'd0);
        respLat = 2; respFromQx = 1'b1;
        applyStimulus(1'b1, 4'b1111);
        tick(1);
        checkOutput("midNextGrantQx", 64'(bm_qx), 64'd5);
        waitDone(10, cyc);
        checkOutput("midNextDone", 64'(done), 64'b0001);
        checkOutput("midNextResult", 64'(resOf(0)), 64'd5);
        applyStimulus(1'b0, '0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/terrain_query_arbiter.md
Name: terrain_query_arbiter

Overview:
- Shares the terrain bitmap's single neighbourhood-lookup port between several moving objects (aliens, gold bags) that need "free direction" or "can fall" answers.
- Serialises requests with round-robin arbitration and issues queries only inside a permitted window (e.g. vertical blanking), so queries never disturb pixel rendering.
- Holds a per-requester registered 4-bit result and pulses a per-requester done strobe.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
COORD_W, 11, coordinate width in pixels
TIMEOUT, 15, maximum WAIT cycles before a query is abandoned (4-bit counter)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
query_window  in  1  1 = new queries may be issued
req  in  NUM_REQ  level request per requester; held until matching done pulse
req_x  in  NUM_REQ*COORD_W  packed top-left X per requester (requester i at bits [i*COORD_W +: COORD_W])
req_y  in  NUM_REQ*COORD_W  packed top-left Y per requester
done  out  NUM_REQ  one-cycle pulse: result for requester i updated
result  out  NUM_REQ*4  packed {up,down,left,right} free flags, 1 = free, requester i at [i*4 +: 4]
bm_qvalid  out  1  one-cycle query strobe to terrain bitmap
bm_qx  out  COORD_W  query X, stable from ISSUE until STORE
bm_qy  out  COORD_W  query Y, stable from ISSUE until STORE
bm_rvalid  in  1  bitmap response valid
bm_rdata  in  4  bitmap response free flags
busy  out  1  1 when state != IDLE
timeout_err  out  1  sticky; set on any abandoned query

Behaviour:
- Reset values: state=IDLE, all outputs 0, result all 0, last_grant=NUM_REQ-1, wait counter 0, latched id 0.
- All outputs are registered. Reset overrides everything; a reset mid-query discards the query, and a later bm_rvalid is ignored.
- FSM states: IDLE, ISSUE, WAIT, STORE.
- IDLE: if query_window=1 and req!=0, pick the winner by round-robin.
  - Search starts at (last_grant+1) mod NUM_REQ and takes the first set bit.
  - Latch the winner id, req_x[id] and req_y[id] into bm_qx/bm_qy, then go to ISSUE.
  - req is sampled only in IDLE.
- ISSUE: bm_qvalid=1 for exactly this one cycle. Clear the wait counter, go to WAIT.
- WAIT:
  - bm_rvalid=1: capture bm_rdata, go to STORE.
  - Otherwise increment the counter. When counter==TIMEOUT, capture 4'b0000 (all blocked, the safe default), set timeout_err, go to STORE.
  - bm_rvalid arriving in the same cycle the counter hits TIMEOUT counts as a valid response, not a timeout.
- STORE: write result[id] with the captured value, done[id]=1 for this cycle, last_grant=id, return to IDLE.
- bm_rvalid outside WAIT is ignored.
- query_window falling while in ISSUE/WAIT/STORE: the in-flight query completes normally; no new issue until the window reopens.
- A requester still asserting req in the IDLE cycle after its done pulse is treated as a new request and is served again in round-robin order.
- Request changes: result for a requester not being served never changes. Coordinate changes after latching do not affect the in-flight query.
- Latency: with req asserted and the window open, IDLE decides in cycle 0, bm_qvalid is high in cycle 1, and a response with bitmap latency L cycles after bm_qvalid gives done/result in cycle 2+L.
  - Throughput: one query per 3+L cycles.
  - Worst case: 3+TIMEOUT.
- The bitmap response is not checked against an id; the one-outstanding-query rule guarantees matching.

Test Plan:
- Single request: window=1, req=0001, req_x[0]=100, req_y[0]=200; bitmap answers 4'b1010 two cycles after bm_qvalid -> bm_qvalid in cycle 1 with bm_qx=100, bm_qy=200; done=0001 and result[0]=1010 in cycle 4; busy high cycles 1-3.
- Round-robin: req=1111 held, window=1, bitmap answers with id-encoded data -> service order 0,1,2,3,0; each done is a single pulse; no requester served twice before the others.
- Window gating: req=0100 with window=0 -> no bm_qvalid. Window rises -> query issued next cycle. Window drops during WAIT -> that query completes and done[2] pulses.
- Timeout: bm_rvalid never asserted -> after ISSUE plus TIMEOUT WAIT cycles, result[i]=0000, done[i] pulses, timeout_err=1 and stays 1. A following query returning 1111 stores 1111 while timeout_err remains 1.
- Stray and late responses: bm_rvalid pulsed in IDLE -> no result change. bm_rvalid on exactly the TIMEOUT cycle with data 0110 -> result=0110 and timeout_err unchanged.
- Reset mid-operation: reset asserted during WAIT, bitmap responds after reset is released -> all results 0, done never pulses, state IDLE, last_grant=NUM_REQ-1 so the next grant goes to requester 0.
